// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the framed instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    RESP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // A program length is usable when it is non-zero and fits the memory depth.
  function automatic logic len_in_range(input logic [7:0] len, input int addr_w);
    logic [31:0] depth;
    depth = 32'd1 << addr_w;
    return (len != 8'd0) && ({24'd0, len} <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the loader.
interface imem_loader_if #(
  parameter int IMEM_ADDR_W = 4
);
  import imem_loader_pkg::*;

  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_ready;
  logic                   mem_we;
  logic [IMEM_ADDR_W-1:0] mem_waddr;
  logic [7:0]             mem_wdata;
  logic                   cpu_hold;
  logic                   load_done;
  logic                   load_err;
  err_code_e              err_code;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata,
           cpu_hold, load_done, load_err, err_code
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata,
           cpu_hold, load_done, load_err, err_code
  );

endinterface

// File: rtl/imem_loader.sv
// Parses SYNC/LEN/data/CSUM download frames, writes the instruction memory and
// keeps the CPU in reset until a checksum-valid program has been loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_ADDR_W = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam int               TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [IMEM_ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]             rem_q, rem_d;
  logic [7:0]             sum_q, sum_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   in_ready_q, in_ready_d;
  logic                   mem_we_q, mem_we_d;
  logic [IMEM_ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [7:0]             mem_wdata_q, mem_wdata_d;
  logic                   cpu_hold_q, cpu_hold_d;
  logic                   load_done_q, load_done_d;
  logic                   load_err_q, load_err_d;
  err_code_e              err_q, err_d;

  logic                   xfer_s;
  logic [7:0]             csum_s;
  logic                   tmr_exp_s;

  assign xfer_s    = bus.in_valid && in_ready_q;
  assign csum_s    = sum_q + bus.in_data;
  assign tmr_exp_s = (tmr_q == TMR_LAST);

  // Next-state and registered-output logic of the frame parser.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    sum_d       = sum_q;
    tmr_d       = tmr_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        tmr_d = {TMR_W{1'b0}};
        if (xfer_s && (bus.in_data == SYNC_BYTE)) begin
          state_d    = LEN;
          cpu_hold_d = 1'b1;
          err_d      = ERR_NONE;
          sum_d      = 8'd0;
          cnt_d      = {IMEM_ADDR_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      LEN: begin
        if (xfer_s) begin
          tmr_d = {TMR_W{1'b0}};
          if (len_in_range(bus.in_data, IMEM_ADDR_W)) begin
            rem_d   = bus.in_data - 8'd1;
            state_d = DATA;
          end else begin
            state_d    = RESP;
            err_d      = ERR_LEN;
            load_err_d = 1'b1;
          end
        end else if (tmr_exp_s) begin
          state_d    = RESP;
          err_d      = ERR_TIMEOUT;
          load_err_d = 1'b1;
          tmr_d      = {TMR_W{1'b0}};
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      DATA: begin
        if (xfer_s) begin
          tmr_d       = {TMR_W{1'b0}};
          mem_we_d    = 1'b1;
          mem_waddr_d = cnt_q;
          mem_wdata_d = bus.in_data;
          cnt_d       = cnt_q + IMEM_ADDR_W'(1);
          sum_d       = csum_s;
          // rem counts bytes still owed after this one; zero means this was the last.
          if (rem_q == 8'd0) begin
            state_d = CHECK;
          end else begin
            rem_d = rem_q - 8'd1;
          end
        end else if (tmr_exp_s) begin
          state_d    = RESP;
          err_d      = ERR_TIMEOUT;
          load_err_d = 1'b1;
          tmr_d      = {TMR_W{1'b0}};
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      CHECK: begin
        if (xfer_s) begin
          tmr_d   = {TMR_W{1'b0}};
          state_d = RESP;
          if (csum_s == 8'd0) begin
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            err_d      = ERR_CSUM;
            load_err_d = 1'b1;
          end
        end else if (tmr_exp_s) begin
          state_d    = RESP;
          err_d      = ERR_TIMEOUT;
          load_err_d = 1'b1;
          tmr_d      = {TMR_W{1'b0}};
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
        tmr_d   = {TMR_W{1'b0}};
      end

      default: begin
        state_d = IDLE;
        tmr_d   = {TMR_W{1'b0}};
      end
    endcase

    in_ready_d = (state_d != RESP);
  end

  // State and output registers; reset forces every output to its idle value at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {IMEM_ADDR_W{1'b0}};
      rem_q       <= 8'd0;
      sum_q       <= 8'd0;
      tmr_q       <= {TMR_W{1'b0}};
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= {IMEM_ADDR_W{1'b0}};
      mem_wdata_q <= 8'd0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      tmr_q       <= tmr_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;
  assign bus.err_code  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// checked against a frame-level model of expected writes and load outcome.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic reset;

  imem_loader_if #(.IMEM_ADDR_W(AW)) bus ();

  imem_loader #(.IMEM_ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         failures  = 0;
  int         wr_count  = 0;
  int         last_code = 0;
  logic       last_hold = 1'b1;
  logic [7:0] tb_mem  [DEPTH];
  logic [7:0] exp_mem [DEPTH];
  logic [7:0] dq [$];

  // Instruction memory attached to the loader's write port.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      tb_mem[bus.mem_waddr] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", (guard < 4), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic idle_gap(input int gmax);
    repeat ($urandom_range(gmax, 0)) @(negedge clk);
  endtask

  task automatic mem_check();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tb_mem[i] !== exp_mem[i]) bad++;
    end
    chk("mem_contents_bad_entries", bad, 0);
  endtask

  task automatic send_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == SYNC_BYTE) b = 8'h5A;
      send_byte(b);
      chk("junk_err_code", bus.err_code, last_code);
      chk("junk_cpu_hold", bus.cpu_hold, last_hold);
    end
  endtask

  task automatic fill_dq(input int n);
    dq.delete();
    for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
  endtask

  function automatic logic [7:0] good_csum();
    int s = 0;
    foreach (dq[i]) s += int'(dq[i]);
    return 8'(256 - (s % 256));
  endfunction

  // Checks the RESP cycle (current falling edge) and the idle cycle after it.
  task automatic expect_result(input bit ok, input int code, input int n_wr, input int wrb);
    chk("load_done", bus.load_done, ok);
    chk("load_err", bus.load_err, !ok);
    chk("err_code", bus.err_code, code);
    chk("cpu_hold", bus.cpu_hold, !ok);
    chk("resp_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("load_done_single", bus.load_done, 0);
    chk("load_err_single", bus.load_err, 0);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("err_code_held", bus.err_code, code);
    chk("write_count", wr_count - wrb, n_wr);
    mem_check();
    last_code = code;
    last_hold = !ok;
  endtask

  task automatic run_frame(input logic [7:0] len, input logic [7:0] csum, input int gmax);
    int n = int'(len);
    bit len_ok;
    int s = 0;
    int wrb;
    bit ok;
    len_ok = (n != 0) && (n <= DEPTH);
    send_byte(SYNC_BYTE);
    chk("sync_cpu_hold", bus.cpu_hold, 1);
    chk("sync_err_code", bus.err_code, 0);
    wrb = wr_count;
    idle_gap(gmax);
    send_byte(len);
    if (!len_ok) begin
      expect_result(1'b0, 1, 0, wrb);
      return;
    end
    for (int i = 0; i < n; i++) begin
      idle_gap(gmax);
      send_byte(dq[i]);
      chk("wr_we", bus.mem_we, 1);
      chk("wr_addr", bus.mem_waddr, i);
      chk("wr_data", bus.mem_wdata, dq[i]);
      exp_mem[i] = dq[i];
      s += int'(dq[i]);
    end
    idle_gap(gmax);
    send_byte(csum);
    chk("csum_no_write", bus.mem_we, 0);
    ok = (((s + int'(csum)) % 256) == 0);
    expect_result(ok, ok ? 0 : 2, n, wrb);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         k;
    int         wrb;
    int         r;
    int         nj;
    logic [7:0] len;
    logic [7:0] csum;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = 8'd0;
      exp_mem[i] = 8'd0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    chk("rst_cpu_hold", bus.cpu_hold, 1);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_waddr", bus.mem_waddr, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_load_done", bus.load_done, 0);
    chk("rst_load_err", bus.load_err, 0);
    chk("rst_no_writes", wr_count, 0);

    dq = '{8'h12, 8'h34, 8'h56};
    run_frame(8'h03, 8'h64, 0);
    run_frame(8'h03, 8'h65, 0);

    send_byte(8'h00);
    send_byte(8'hFF);
    chk("junk_err_code_kept", bus.err_code, 2);
    run_frame(8'h00, 8'h00, 0);
    run_frame(8'h11, 8'h00, 0);
    fill_dq(16);
    run_frame(8'h10, good_csum(), 0);

    // Timeout: counted in falling edges after the last accepted byte.
    send_byte(SYNC_BYTE);
    wrb = wr_count;
    send_byte(8'h02);
    send_byte(8'h12);
    chk("to_wr_data", bus.mem_wdata, 8'h12);
    exp_mem[0] = 8'h12;
    k = 0;
    while (bus.load_err !== 1'b1 && k < TO + 8) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", k, TO);
    expect_result(1'b0, 3, 1, wrb);
    send_junk(1);
    fill_dq(5);
    run_frame(8'h05, good_csum(), 2);

    // Reset after the second data byte kills that byte's pending write.
    fill_dq(4);
    dq[1] = ~exp_mem[1];
    send_byte(SYNC_BYTE);
    send_byte(8'h04);
    send_byte(dq[0]);
    exp_mem[0] = dq[0];
    send_byte(dq[1]);
    chk("pre_reset_we", bus.mem_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_mem_we", bus.mem_we, 0);
    chk("arst_mem_waddr", bus.mem_waddr, 0);
    chk("arst_mem_wdata", bus.mem_wdata, 0);
    chk("arst_cpu_hold", bus.cpu_hold, 1);
    chk("arst_load_done", bus.load_done, 0);
    chk("arst_load_err", bus.load_err, 0);
    chk("arst_err_code", bus.err_code, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_check();
    last_code = 0;
    last_hold = 1'b1;
    fill_dq(7);
    run_frame(8'h07, good_csum(), 0);

    for (int f = 0; f < 25; f++) begin
      r = $urandom_range(9, 0);
      case (r)
        0:       len = 8'h00;
        1:       len = 8'($urandom_range(255, 17));
        2:       len = 8'h10;
        default: len = 8'($urandom_range(16, 1));
      endcase
      fill_dq((int'(len) <= DEPTH) ? int'(len) : 0);
      csum = good_csum();
      if ($urandom_range(2, 0) == 0) csum = csum + 8'($urandom_range(255, 1));
      nj = $urandom_range(2, 0);
      send_junk(nj);
      run_frame(len, csum, ((f % 3) == 0) ? TO - 2 : 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
